// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: ALU op codes, MIPS opcode/funct values, operand selects
// and the decoded-entry struct. ALU_CTRL_ILLEGAL_EN adds a per-entry illegal flag.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'h0, ALU_SUBU = 4'h1, ALU_SLT = 4'h2, ALU_SLTU = 4'h3,
    ALU_AND  = 4'h4, ALU_OR   = 4'h5, ALU_XOR = 4'h6, ALU_LUI  = 4'h7,
    ALU_SLL  = 4'h8, ALU_SRL  = 4'h9, ALU_SRA = 4'hA, ALU_NOR  = 4'hB,
    ALU_XXX  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    BSEL_RT = 2'd0, BSEL_IMM = 2'd1, BSEL_SHAMT = 2'd2, BSEL_RS = 2'd3
  } b_sel_e;

  localparam logic A_SEL_RS = 1'b0;
  localparam logic A_SEL_RT = 1'b1;

  typedef enum logic [1:0] {BUF_EMPTY = 2'd0, BUF_ONE = 2'd1, BUF_TWO = 2'd2} buf_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_J    = 6'h02, OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04, OPC_BNE  = 6'h05, OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A, OPC_SLTIU = 6'h0B, OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LB    = 6'h20, OPC_LHU  = 6'h25;
  localparam logic [5:0] OPC_SB    = 6'h28, OPC_SH   = 6'h29, OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_e     op;
    logic        a_sel;
    b_sel_e      b_sel;
    logic [31:0] imm32;
    logic [31:0] tag;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic        illegal;
`endif
  } entry_t;

  function automatic entry_t make_reset_entry(input logic [31:0] tag);
    entry_t e;
    e     = '0;
    e.op  = ALU_XXX;
    e.tag = tag;
    return e;
  endfunction

endpackage

// File: rtl/ctrl_skid_buf.sv
// Generic 2-entry valid/ready buffer. in_ready is registered, so a downstream stall
// never reaches the upstream side combinationally.
module ctrl_skid_buf
  import alu_pkg::*;
#(
  parameter int  DEPTH     = 2,
  parameter type T         = entry_t,
  parameter T    RESET_VAL = T'('0)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  buf_state_e r_state, w_state_next;
  logic       r_in_ready;
  T           r_head, r_tail;
  logic       w_push, w_pop;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = (r_state != BUF_EMPTY) && out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      BUF_EMPTY: if (w_push) w_state_next = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)      w_state_next = BUF_TWO;
        else if (!w_push && w_pop) w_state_next = BUF_EMPTY;
      end
      BUF_TWO:   if (w_pop) w_state_next = BUF_ONE;
      default:   w_state_next = BUF_EMPTY;
    endcase
    if (flush) w_state_next = BUF_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BUF_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= int'(w_state_next) < DEPTH;
    end
  end

  // Head feeds the outputs directly, so it alone carries the reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= RESET_VAL;
    end else if (!flush) begin
      unique case (r_state)
        BUF_EMPTY: if (w_push) r_head <= in_data;
        BUF_ONE:   if (w_push && w_pop) r_head <= in_data;
        BUF_TWO:   if (w_pop) r_head <= r_tail;
        default:   ;
      endcase
    end
  end

  // NOTE: the tail slot is never observed while invalid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!flush && r_state == BUF_ONE && w_push && !w_pop) r_tail <= in_data;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != BUF_EMPTY);
  assign out_data  = r_head;

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered MIPS decode stage producing ALU op, operand selects and extended immediate.
// Define ALU_CTRL_ILLEGAL_EN to add the out_illegal flag.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic        out_a_sel,
  output logic [1:0]  out_b_sel,
  output logic [31:0] out_imm32,
`ifdef ALU_CTRL_ILLEGAL_EN
  output logic        out_illegal,
`endif
  output logic [31:0] out_tag
);

  localparam entry_t RESET_ENTRY = make_reset_entry(RESET_PC_TAG);

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] tag);
    entry_t      d;
    logic [5:0]  opc, fn;
    logic [31:0] sext, zext;
    opc     = instr[31:26];
    fn      = instr[5:0];
    sext    = {{16{instr[15]}}, instr[15:0]};
    zext    = {16'h0, instr[15:0]};
    d       = '0;
    d.op    = ALU_XXX;
    d.tag   = tag;
    if (opc == OPC_RTYPE) begin
      unique case (fn)
        FN_ADDU, FN_JR, FN_JALR: d.op = ALU_ADDU;
        FN_SUBU: d.op = ALU_SUBU;
        FN_AND:  d.op = ALU_AND;
        FN_OR:   d.op = ALU_OR;
        FN_XOR:  d.op = ALU_XOR;
        FN_NOR:  d.op = ALU_NOR;
        FN_SLT:  d.op = ALU_SLT;
        FN_SLTU: d.op = ALU_SLTU;
        FN_SLL, FN_SRL, FN_SRA: begin
          d.op    = (fn == FN_SLL) ? ALU_SLL : (fn == FN_SRL) ? ALU_SRL : ALU_SRA;
          d.a_sel = A_SEL_RT;
          d.b_sel = BSEL_SHAMT;
          // The shift amount travels in imm32 since raw instructions are not kept.
          d.imm32 = {27'h0, instr[10:6]};
        end
        FN_SLLV, FN_SRLV, FN_SRAV: begin
          d.op    = (fn == FN_SLLV) ? ALU_SLL : (fn == FN_SRLV) ? ALU_SRL : ALU_SRA;
          d.a_sel = A_SEL_RT;
          d.b_sel = BSEL_RS;
        end
        default: d.op = ALU_XXX;
      endcase
    end else if (opc == OPC_BEQ || opc == OPC_BNE) begin
      d.op    = ALU_SUBU;
      d.imm32 = sext;
    end else begin
      d.b_sel = BSEL_IMM;
      unique case (opc)
        OPC_ADDIU: begin d.op = ALU_ADDU; d.imm32 = sext; end
        OPC_SLTI:  begin d.op = ALU_SLT;  d.imm32 = sext; end
        OPC_SLTIU: begin d.op = ALU_SLTU; d.imm32 = sext; end
        OPC_ANDI:  begin d.op = ALU_AND;  d.imm32 = zext; end
        OPC_ORI:   begin d.op = ALU_OR;   d.imm32 = zext; end
        OPC_XORI:  begin d.op = ALU_XOR;  d.imm32 = zext; end
        OPC_LUI:   begin d.op = ALU_LUI;  d.imm32 = {instr[15:0], 16'h0}; end
        OPC_SB, OPC_SH, OPC_SW: begin d.op = ALU_ADDU; d.imm32 = sext; end
        default: begin
          if (opc >= OPC_LB && opc <= OPC_LHU) begin
            d.op    = ALU_ADDU;
            d.imm32 = sext;
          end else begin
            d.b_sel = BSEL_RT;
          end
        end
      endcase
    end
`ifdef ALU_CTRL_ILLEGAL_EN
    d.illegal = (d.op == ALU_XXX) && !(opc == OPC_J || opc == OPC_JAL);
`endif
    return d;
  endfunction

  entry_t w_in_entry, w_head;

  assign w_in_entry = decode(in_instr, in_tag);

  ctrl_skid_buf #(
    .DEPTH     (DEPTH),
    .T         (entry_t),
    .RESET_VAL (RESET_ENTRY)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign out_alu_op = w_head.op;
  assign out_a_sel  = w_head.a_sel;
  assign out_b_sel  = w_head.b_sel;
  assign out_imm32  = w_head.imm32;
  assign out_tag    = w_head.tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign out_illegal = w_head.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: driver pushes hand-computed entries, monitor pops on delivery.
module tb_alu_ctrl_stage;

  localparam logic [31:0] RESET_TAG = 32'hBFC0_0000;

  typedef struct packed {
    logic [3:0]  op;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_tag;
  logic [3:0]  out_alu_op;
  logic        out_a_sel;
  logic [1:0]  out_b_sel;
  logic [31:0] out_imm32, out_tag;
  logic        w_ill;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_ctrl_stage #(.DEPTH(2), .RESET_PC_TAG(RESET_TAG)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_a_sel  (out_a_sel),
    .out_b_sel  (out_b_sel),
    .out_imm32  (out_imm32),
`ifdef ALU_CTRL_ILLEGAL_EN
    .out_illegal(w_ill),
`endif
    .out_tag    (out_tag)
  );

`ifndef ALU_CTRL_ILLEGAL_EN
  assign w_ill = 1'b0;
`endif

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic a, input logic [1:0] b,
                              input logic [31:0] imm, input logic ill);
    exp_t e;
    e.op = op; e.a_sel = a; e.b_sel = b; e.imm = imm; e.tag = 32'h0;
`ifdef ALU_CTRL_ILLEGAL_EN
    e.ill = ill;
`else
    e.ill = 1'b0 & ill;
`endif
    return e;
  endfunction

  task automatic send(input logic [31:0] instr, input logic [31:0] tag, input exp_t e);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1; in_instr = instr; in_tag = tag;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.tag = tag;
        sb.push_back(e);
        accepted = 1'b1;
      end
    end
    check("accept", 72'(accepted), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  initial begin
    exp_t e, act;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          check("unexpected_output", 72'(sb.size()), 72'(1));
        end else begin
          e   = sb.pop_front();
          act = {out_alu_op, out_a_sel, out_b_sel, out_imm32, out_tag, w_ill};
          check("entry", act, e);
        end
      end
    end
  end

  task automatic flush_test(input int n);
    int d0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++)
      send(32'h2508_0001 + i, 32'h200 + 4 * i, mk(4'h0, 1'b0, 2'd1, 32'h1 + i, 1'b0));
    in_valid = 1'b1; in_instr = 32'h3422_0055; in_tag = 32'h2FC;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 72'(out_valid), 72'(0));
    check("flush_in_ready", 72'(in_ready), 72'(1));
    out_ready = 1'b1;
    d0 = delivered;
    repeat (5) @(negedge clk);
    #1;
    check("flush_nothing_emerges", 72'(delivered - d0), 72'(0));
  endtask

  initial begin
    int c0, d0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_in_ready", 72'(in_ready), 72'(1));
    check("rst_fields", {out_alu_op, out_a_sel, out_b_sel, out_imm32, out_tag, w_ill},
          {4'hF, 1'b0, 2'd0, 32'h0, RESET_TAG, 1'b0});

    // Single-cycle latency from an empty buffer.
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h2508_FFFF, 32'h1000, mk(4'h0, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0));
    @(negedge clk);
    check("latency_out_valid", 72'(out_valid), 72'(1));
    @(posedge clk); #1;

    // Back-to-back decode vectors at one per cycle.
    c0 = cyc;
    send(32'h3022_8000, 32'h1004, mk(4'h4, 1'b0, 2'd1, 32'h0000_8000, 1'b0));
    send(32'h3C01_1234, 32'h1008, mk(4'h7, 1'b0, 2'd1, 32'h1234_0000, 1'b0));
    send(32'h0005_20C0, 32'h100C, mk(4'h8, 1'b1, 2'd2, 32'h0000_0003, 1'b0));
    send(32'h0044_1807, 32'h1010, mk(4'hA, 1'b1, 2'd3, 32'h0, 1'b0));
    send(32'h0022_1823, 32'h1014, mk(4'h1, 1'b0, 2'd0, 32'h0, 1'b0));
    send(32'h0022_1827, 32'h1018, mk(4'hB, 1'b0, 2'd0, 32'h0, 1'b0));
    send(32'h8C22_FFFC, 32'h101C, mk(4'h0, 1'b0, 2'd1, 32'hFFFF_FFFC, 1'b0));
    send(32'h2C22_8000, 32'h1020, mk(4'h3, 1'b0, 2'd1, 32'hFFFF_8000, 1'b0));
    send(32'h03E0_0008, 32'h1024, mk(4'h0, 1'b0, 2'd0, 32'h0, 1'b0));
    send(32'h0800_0010, 32'h1028, mk(4'hF, 1'b0, 2'd0, 32'h0, 1'b0));
    send(32'hFC00_0000, 32'h102C, mk(4'hF, 1'b0, 2'd0, 32'h0, 1'b1));
    check("throughput_cycles", 72'(cyc - c0), 72'(11));
    send(32'h3822_0001, 32'h1030, mk(4'h6, 1'b0, 2'd1, 32'h1, 1'b0));
    send(32'h0022_182A, 32'h1034, mk(4'h2, 1'b0, 2'd0, 32'h0, 1'b0));
    send(32'h0005_20C2, 32'h1038, mk(4'h9, 1'b1, 2'd2, 32'h3, 1'b0));
    repeat (3) @(negedge clk);

    // Stall with out_ready low: two accepted, third blocked, then in-order drain.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'hAC22_FFF0, 32'h100, mk(4'h0, 1'b0, 2'd1, 32'hFFFF_FFF0, 1'b0));
    send(32'h3422_0001, 32'h104, mk(4'h5, 1'b0, 2'd1, 32'h1, 1'b0));
    in_valid = 1'b1; in_instr = 32'h0022_1823; in_tag = 32'h108;
    repeat (2) @(negedge clk);
    check("stall_in_ready", 72'(in_ready), 72'(0));
    check("stall_out_valid", 72'(out_valid), 72'(1));
    check("stall_head_stable", {out_tag, out_alu_op, out_imm32}, {32'h100, 4'h0, 32'hFFFF_FFF0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    d0 = delivered;
    send(32'h0022_1823, 32'h108, mk(4'h1, 1'b0, 2'd0, 32'h0, 1'b0));
    @(negedge clk); #1;
    check("drain_one_per_cycle", 72'(delivered - d0), 72'(3));
    check("drain_in_ready", 72'(in_ready), 72'(1));
    check("drain_sb_empty", 72'(sb.size()), 72'(0));

    // Flush with two entries buffered, then with one entry and a live input.
    @(posedge clk); #1;
    flush_test(2);
    @(posedge clk); #1;
    flush_test(1);

    // Reset while two entries are buffered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h2508_0010, 32'h400, mk(4'h0, 1'b0, 2'd1, 32'h10, 1'b0));
    send(32'h2508_0020, 32'h404, mk(4'h0, 1'b0, 2'd1, 32'h20, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 72'(out_valid), 72'(0));
    check("midrst_fields", {out_alu_op, out_tag, in_ready}, {4'hF, RESET_TAG, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h2508_0030, 32'h500, mk(4'h0, 1'b0, 2'd1, 32'h30, 1'b0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("final_sb_empty", 72'(sb.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered decode stage. Turns a 32-bit MIPS instruction into the 4-bit ALU operation code plus operand-select and extended-immediate fields.
- Drives the ALU's control inputs: it is the producer end of the ALUop interface that the ALU consumes.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a 2-entry skid buffer so that execute stalls never create a combinational path back to fetch.

Parameters:
- DEPTH, 2, skid entries; only 2 is supported.
- RESET_PC_TAG, 0, reset value of out_tag.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_tag  in  32  PC or sideband, passed through untouched
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts
- out_alu_op  out  4  ALU operation code
- out_a_sel  out  1  0=rs, 1=rt
- out_b_sel  out  2  0=rt, 1=imm32, 2=shamt (zero-extended), 3=rs
- out_imm32  out  32  extended immediate
- out_tag  out  32  tag of head entry

Behaviour:
- Reset (rst high at edge): buffer empty; out_valid=0; in_ready=1; out_alu_op=XXX (4'hF); out_a_sel=0; out_b_sel=0; out_imm32=0; out_tag=RESET_PC_TAG. Reset overrides flush and all handshakes. Reset mid-transfer drops every entry.
- Transfers: input transfer occurs when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: an accepted instruction appears at the outputs on the next cycle if the buffer was empty.
- Full throughput: 1 instruction/cycle while out_ready is held high.
- in_ready = (count<2), registered from next-state count.
- Buffer states: EMPTY, ONE, TWO.
  - EMPTY->ONE on an input transfer.
  - ONE->TWO on input without output.
  - ONE->EMPTY on output without input.
  - ONE->ONE on simultaneous input and output.
  - TWO->ONE on output; input is impossible because in_ready=0.
- Order is strictly FIFO. Output fields are stable while out_valid&&!out_ready.
- Decoding is done at entry time; decoded fields are stored, raw instructions are not.
- flush: next state EMPTY, out_valid=0, in_ready=1. A same-cycle input is dropped. A same-cycle output transfer still counts as delivered.
- Decode rules, R-type (opcode 0), by funct:
  - 21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU: a=rs, b=rt.
  - 00 SLL, 02 SRL, 03 SRA: a=rt, b=shamt.
  - 04/06/07 SLLV/SRLV/SRAV: a=rt, b=rs.
  - 08/09 JR/JALR: ADDU, a=rs, b=rt.
- Decode rules, I-type:
  - 09 ADDIU: ADDU. 0A SLTI: SLT. 0B SLTIU: SLTU. All sign-extended.
  - 0C ANDI, 0D ORI, 0E XORI: zero-extended.
  - 0F LUI: op LUI, imm32={imm,16'h0}.
  - Loads 20–25 and stores 28/29/2B: ADDU, sign-extended.
  - 04/05 BEQ/BNE: SUBU, a=rs, b=rt.
  - J/JAL (02/03): XXX.
- Anything else: op XXX, imm32=0.
- ALU codes: ADDU 0, SUBU 1, SLT 2, SLTU 3, AND 4, OR 5, XOR 6, LUI 7, SLL 8, SRL 9, SRA A, NOR B, XXX F.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- When defined:
  - Adds output out_illegal (1 bit, reset 0). It is stored per entry and set for any instruction decoding to XXX other than J/JAL.
  - Illegal entries still flow normally.
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op code constants;
  - opcode/funct constants;
  - the b_sel encodings;
  - a decoded-entry struct typedef (op, a_sel, b_sel, imm32, tag[, illegal]).
- Natural sub-module: ctrl_skid_buf, a generic 2-entry valid/ready buffer over the entry struct.
- The decode is a combinational function in alu_ctrl_stage.

Test Plan:
- Reset, then ADDIU 0x2508FFFF (imm 0xFFFF) -> next cycle out_valid=1, op=0, b_sel=1, imm32=FFFFFFFF.
- ANDI imm 0x8000 -> imm32=00008000, op=4. LUI imm 0x1234 -> op=7, imm32=12340000.
- SLL rt=5, shamt=3 -> op=8, a_sel=1, b_sel=2. SRAV -> op=A, a_sel=1, b_sel=3.
- Hold out_ready=0 while streaming 3 instructions:
  - 2 are accepted, then in_ready=0.
  - Release out_ready: entries are delivered in order, one per cycle, and in_ready returns to 1.
- Stall with 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no entry ever emerges.
- Assert rst mid-stream with 2 entries -> next cycle out_valid=0, op=F, out_tag=RESET_PC_TAG. Opcode 0x3F with the macro defined -> op=F, out_illegal=1.
